// File: rtl/scoreboard_pkg.sv
// Shared constants for the scoreboard display path.
// Holds the 7-segment patterns (active-high, bit order {g,f,e,d,c,b,a}),
// the BCD nibble width, the one-hot digit-select encodings and the score limits.
package scoreboard_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] DIG_UNITS = 2'b01;
  localparam logic [1:0] DIG_TENS  = 2'b10;

  localparam logic [7:0] SCORE_MAX = 8'h99;
  localparam logic [7:0] SCORE_MIN = 8'h00;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to 7-segment pattern decoder.
// Ports:
//   bcd_i  - 4-bit BCD digit; codes 10..15 decode to blank
//   seg_o  - active-high segments {g,f,e,d,c,b,a}
module seg7_decoder
  import scoreboard_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [6:0]       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display_driver.sv
// Two-digit BCD score keeper with multiplexed 7-segment display drive.
// Steps saturate at 00 and 99; a step rejected at a limit blanks the display
// for FLASH_TICKS cycles. Digits alternate every REFRESH_TICKS cycles.
// Ports:
//   clk_1mhz    - system clock
//   rst_n       - synchronous active-low reset
//   count_up    - single-cycle increment pulse
//   count_down  - single-cycle decrement pulse
//   clear_i     - level, forces the score to 00
//   score_bcd   - registered score, [7:4] tens, [3:0] units
//   seg         - registered segments {g,f,e,d,c,b,a}, active-high
//   digit_sel   - registered one-hot digit enable (01 units, 10 tens)
//   flash_o     - high while the rejection blank is active
module score_display_driver
  import scoreboard_pkg::*;
#(
  parameter int unsigned REFRESH_TICKS = 5000,
  parameter int unsigned FLASH_TICKS   = 250000
) (
  input  logic       clk_1mhz,
  input  logic       rst_n,
  input  logic       count_up,
  input  logic       count_down,
  input  logic       clear_i,
  output logic [7:0] score_bcd,
  output logic [6:0] seg,
  output logic [1:0] digit_sel,
  output logic       flash_o
);

  localparam int unsigned RefW   = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam int unsigned FlashW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam logic [RefW-1:0]   RefLast   = RefW'(REFRESH_TICKS - 1);
  localparam logic [FlashW-1:0] FlashLoad = FlashW'(FLASH_TICKS - 1);

  logic [7:0]        score_q, score_d;
  logic [FlashW-1:0] flash_cnt_q, flash_cnt_d;
  logic              flash_q, flash_d;
  logic [RefW-1:0]   ref_cnt_q, ref_cnt_d;
  logic [1:0]        digit_sel_q, digit_sel_d;
  logic [6:0]        seg_q, seg_d;

  logic [BCD_W-1:0]  tens, units, nibble;
  logic [6:0]        dec_seg;
  logic              trigger;

  assign tens  = score_q[7:4];
  assign units = score_q[3:0];

  // Score update in priority order; the score is only ever stepped as BCD.
  always_comb begin
    score_d = score_q;
    trigger = 1'b0;
    if (clear_i) begin
      score_d = SCORE_MIN;
    end else if (count_up && count_down) begin
      score_d = score_q;
    end else if (count_up) begin
      if (score_q == SCORE_MAX) begin
        trigger = 1'b1;
      end else if (units == 4'd9) begin
        score_d = {tens + 4'd1, 4'd0};
      end else begin
        score_d = {tens, units + 4'd1};
      end
    end else if (count_down) begin
      if (score_q == SCORE_MIN) begin
        trigger = 1'b1;
      end else if (units == 4'd0) begin
        score_d = {tens - 4'd1, 4'd9};
      end else begin
        score_d = {tens, units - 4'd1};
      end
    end
  end

  // Flash stays high until the cycle after the counter has reached zero,
  // giving exactly FLASH_TICKS high cycles; a new trigger simply reloads.
  always_comb begin
    flash_d     = flash_q;
    flash_cnt_d = flash_cnt_q;
    if (trigger) begin
      flash_d     = 1'b1;
      flash_cnt_d = FlashLoad;
    end else if (flash_q) begin
      if (flash_cnt_q == '0) begin
        flash_d = 1'b0;
      end else begin
        flash_cnt_d = flash_cnt_q - FlashW'(1);
      end
    end
  end

  always_comb begin
    ref_cnt_d   = ref_cnt_q + RefW'(1);
    digit_sel_d = digit_sel_q;
    if (ref_cnt_q == RefLast) begin
      ref_cnt_d   = '0;
      digit_sel_d = (digit_sel_q == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
    end
  end

  // Decode against the next digit select so seg and digit_sel change together.
  assign nibble = (digit_sel_d == DIG_TENS) ? tens : units;

  seg7_decoder u_dec (
    .bcd_i (nibble),
    .seg_o (dec_seg)
  );

  always_comb begin
    seg_d = dec_seg;
    if (flash_q || ((digit_sel_d == DIG_TENS) && (tens == 4'd0))) begin
      seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk_1mhz) begin
    if (!rst_n) begin
      score_q     <= SCORE_MIN;
      flash_cnt_q <= '0;
      flash_q     <= 1'b0;
      ref_cnt_q   <= '0;
      digit_sel_q <= DIG_UNITS;
      seg_q       <= SEG_BLANK;
    end else begin
      score_q     <= score_d;
      flash_cnt_q <= flash_cnt_d;
      flash_q     <= flash_d;
      ref_cnt_q   <= ref_cnt_d;
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_d;
    end
  end

  assign score_bcd = score_q;
  assign seg       = seg_q;
  assign digit_sel = digit_sel_q;
  assign flash_o   = flash_q;

endmodule
